// File: rtl/uart_tx_buffer.sv
// Bus-side TX front end for the uart: buffers core byte writes in a FIFO and drains them one at a time.
// Optional UART_TX_BUFFER_FLUSH_EN adds a FLUSH register (addr[3:2]==2) that empties the FIFO.
module uart_tx_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        buf_valid,
    input  logic        buf_instr,
    input  logic [31:0] buf_addr,
    input  logic [31:0] buf_wdata,
    input  logic [3:0]  buf_wstrb,
    output logic [31:0] buf_rdata,
    output logic        buf_ready,
    output logic        uart_valid,
    output logic        uart_instr,
    output logic [31:0] uart_addr,
    output logic [31:0] uart_wdata,
    output logic [3:0]  uart_wstrb,
    input  logic [31:0] uart_rdata,
    input  logic        uart_ready
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] SEL_DATA   = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
`ifdef UART_TX_BUFFER_FLUSH_EN
    localparam logic [1:0] SEL_FLUSH  = 2'd2;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT_W,
        WAIT_R
    } state_t;

    state_t state;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             pending;
    logic [31:0]      req_addr;
    logic [7:0]       req_byte;
    logic             req_write;
    logic [31:0]      data_addr;

    logic             cur_valid;
    logic [31:0]      cur_addr;
    logic [7:0]       cur_byte;
    logic             cur_write;
    logic [1:0]       cur_sel;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             rd_issue;
    logic             local_done;
    logic             flush;
    logic [31:0]      status_word;
    logic [31:0]      local_rdata;

    logic             unused_bits;

    assign unused_bits = &{1'b0, buf_instr, buf_wdata[31:8]};
    assign uart_instr  = 1'b0;

    // A fresh pulse is served in its own cycle; otherwise the latched copy is.
    always_comb begin
        cur_valid = pending | buf_valid;
        cur_addr  = pending ? req_addr  : buf_addr;
        cur_byte  = pending ? req_byte  : buf_wdata[7:0];
        cur_write = pending ? req_write : (|buf_wstrb);
        cur_sel   = cur_addr[3:2];
    end

    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        empty      = (count == '0);
        push       = cur_valid && cur_write && (cur_sel == SEL_DATA) && !full;
        pop        = (state == IDLE) && !empty;
        rd_issue   = cur_valid && !cur_write && (cur_sel == SEL_DATA) && (state == IDLE) && empty;
        local_done = cur_valid && (cur_sel != SEL_DATA);
`ifdef UART_TX_BUFFER_FLUSH_EN
        flush      = cur_valid && cur_write && (cur_sel == SEL_FLUSH);
`else
        flush      = 1'b0;
`endif
    end

    always_comb begin
        status_word              = '0;
        status_word[0]           = full;
        status_word[1]           = empty;
        status_word[2]           = (state != IDLE);
        status_word[8 +: CNT_W]  = count;
        local_rdata              = (!cur_write && (cur_sel == SEL_STATUS)) ? status_word : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cur_byte;
        end
    end

    // Request handling, FIFO bookkeeping and the drain FSM share one register block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pending    <= 1'b0;
            req_addr   <= '0;
            req_byte   <= '0;
            req_write  <= 1'b0;
            data_addr  <= '0;
            buf_rdata  <= '0;
            buf_ready  <= 1'b0;
            uart_valid <= 1'b0;
            uart_addr  <= '0;
            uart_wdata <= '0;
            uart_wstrb <= 4'h0;
        end else begin
            buf_ready  <= 1'b0;
            buf_rdata  <= '0;
            uart_valid <= 1'b0;

            if (buf_valid && !pending) begin
                pending   <= 1'b1;
                req_addr  <= buf_addr;
                req_byte  <= buf_wdata[7:0];
                req_write <= |buf_wstrb;
            end

            if (push || local_done) begin
                pending   <= 1'b0;
                buf_ready <= 1'b1;
                buf_rdata <= local_done ? local_rdata : '0;
            end

            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                data_addr <= cur_addr;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Flush wins over a same-cycle pop so the FIFO ends up empty.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        uart_valid <= 1'b1;
                        uart_wstrb <= 4'hF;
                        uart_wdata <= {24'b0, mem[rd_ptr]};
                        uart_addr  <= data_addr;
                        state      <= WAIT_W;
                    end else if (rd_issue) begin
                        uart_valid <= 1'b1;
                        uart_wstrb <= 4'h0;
                        uart_wdata <= '0;
                        uart_addr  <= cur_addr;
                        state      <= WAIT_R;
                    end
                end
                WAIT_W: begin
                    if (uart_ready) begin
                        state <= IDLE;
                    end
                end
                WAIT_R: begin
                    if (uart_ready) begin
                        state     <= IDLE;
                        pending   <= 1'b0;
                        buf_ready <= 1'b1;
                        buf_rdata <= uart_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
